// File: rtl/gauss_ctrl_if.sv
// ============================================================================
// Module      : gauss_ctrl_if
// Description : CPU bus, pixel RAM and filter-datapath signals of gauss_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gauss_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              cs_i;
    logic              sel_i;
    logic              we_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              src_rd_o;
    logic [ADDR_W-1:0] src_addr_o;
    logic [7:0]        src_data_i;
    logic              flt_valid_o;
    logic [7:0]        flt_pix_o;
    logic              flt_ready_i;
    logic              flt_valid_i;
    logic [7:0]        flt_pix_i;
    logic              dst_we_o;
    logic [ADDR_W-1:0] dst_addr_o;
    logic [7:0]        dst_data_o;
    logic              irq_o;

    modport slave (
        input  cs_i, sel_i, we_i, wdata_i, src_data_i, flt_ready_i, flt_valid_i, flt_pix_i,
        output rdata_o, src_rd_o, src_addr_o, flt_valid_o, flt_pix_o,
               dst_we_o, dst_addr_o, dst_data_o, irq_o
    );

    modport master (
        output cs_i, sel_i, we_i, wdata_i, src_data_i, flt_ready_i, flt_valid_i, flt_pix_i,
        input  rdata_o, src_rd_o, src_addr_o, flt_valid_o, flt_pix_o,
               dst_we_o, dst_addr_o, dst_data_o, irq_o
    );
endinterface

`default_nettype wire

// File: rtl/gauss_ctrl.sv
// ============================================================================
// Module      : gauss_ctrl
// Description : Register-mapped sequencer streaming N pixels src RAM -> filter
//               -> dst RAM, with done status and level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gauss_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    gauss_ctrl_if.slave   bus
);

    localparam int CW = ADDR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_in_cnt;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_n;
    logic [7:0]    r_pix;
    logic [7:0]    r_last;
    logic          r_done;
    logic          r_irq_en;
    logic          r_irq;
    logic          r_feed_first;

    logic          w_ctrl_wr;
    logic          w_start;
    logic          w_clr;
    logic          w_abort;
    logic          w_busy;
    logic          w_start_acc;
    logic          w_abort_acc;
    logic          w_out_acc;
    logic [CW-1:0] w_n_new;
    logic [CW-1:0] w_in_inc;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_ctrl_wr   = bus.cs_i & bus.we_i & ~bus.sel_i;
    assign w_start     = w_ctrl_wr & bus.wdata_i[0];
    assign w_clr       = w_ctrl_wr & bus.wdata_i[2];
    assign w_abort     = w_ctrl_wr & bus.wdata_i[3];
    assign w_n_new     = bus.wdata_i[16 +: CW];
    assign w_in_inc    = r_in_cnt + 1'b1;
    assign w_unused    = ^{bus.wdata_i[15:4], bus.wdata_i[31:16+CW]};

    assign w_busy      = (r_state == S_FETCH) | (r_state == S_FEED) | (r_state == S_DRAIN);
    assign w_abort_acc = w_abort & w_busy;
    // Abort outranks start even when both land in the same write.
    assign w_start_acc = w_start & ~w_abort & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_out_acc   = bus.flt_valid_i & w_busy & (r_out_cnt != r_n);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_n          <= '0;
            r_pix        <= '0;
            r_last       <= '0;
            r_done       <= 1'b0;
            r_irq_en     <= 1'b0;
            r_irq        <= 1'b0;
            r_feed_first <= 1'b0;
        end else begin
            r_feed_first <= 1'b0;
            r_irq        <= r_done & r_irq_en;
            if (w_ctrl_wr) begin
                r_irq_en <= bus.wdata_i[1];
            end
            if (w_out_acc) begin
                r_out_cnt <= r_out_cnt + 1'b1;
                r_last    <= bus.flt_pix_i;
            end
            if (w_clr) begin
                r_done <= 1'b0;
            end
            // Later assignments below deliberately override clr_done.
            if (w_abort_acc) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_start_acc) begin
                            r_in_cnt  <= '0;
                            r_out_cnt <= '0;
                            r_n       <= w_n_new;
                            r_done    <= (w_n_new == '0);
                            r_state   <= (w_n_new == '0) ? S_DONE : S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        r_state      <= S_FEED;
                        r_feed_first <= 1'b1;
                    end
                    S_FEED: begin
                        if (r_feed_first) begin
                            r_pix <= bus.src_data_i;
                        end
                        if (bus.flt_ready_i) begin
                            r_in_cnt <= w_in_inc;
                            r_state  <= (w_in_inc == r_n) ? S_DRAIN : S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        if (r_out_cnt == r_n) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // First FEED cycle forwards the RAM output directly; later cycles hold it.
    assign bus.src_rd_o    = (r_state == S_FETCH);
    assign bus.src_addr_o  = (r_state == S_FETCH) ? r_in_cnt[ADDR_W-1:0] : '0;
    assign bus.flt_valid_o = (r_state == S_FEED);
    assign bus.flt_pix_o   = (r_state != S_FEED) ? 8'd0 :
                             (r_feed_first ? bus.src_data_i : r_pix);
    assign bus.dst_we_o    = w_out_acc;
    assign bus.dst_addr_o  = w_out_acc ? r_out_cnt[ADDR_W-1:0] : '0;
    assign bus.dst_data_o  = w_out_acc ? bus.flt_pix_i : 8'd0;
    assign bus.irq_o       = r_irq;

    always_comb begin
        w_status            = '0;
        w_status[0]         = w_busy;
        w_status[1]         = r_done;
        w_status[2]         = r_irq_en;
        w_status[16 +: CW]  = r_out_cnt;
    end

    assign bus.rdata_o = !bus.cs_i ? 32'd0 :
                         (bus.sel_i ? {24'd0, r_last} : w_status);

endmodule

`default_nettype wire

// File: tb/tb_gauss_ctrl.sv
// ============================================================================
// Module      : tb_gauss_ctrl
// Description : Directed self-checking bench for gauss_ctrl with RAM/filter models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gauss_ctrl;

    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gauss_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    gauss_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] src_mem [0:1023];
    logic       m_v1, m_v2;
    logic [7:0] m_p1, m_p2;
    logic       stray_v = 1'b0;
    logic [7:0] stray_p = 8'd0;

    int src_log      [0:63];
    int dst_addr_log [0:63];
    int dst_data_log [0:63];
    int src_n  = 0;
    int dst_n  = 0;
    int feed_n = 0;

    // Source RAM: one-cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.src_data_i <= 8'd0;
        else if (bus.src_rd_o) bus.src_data_i <= src_mem[bus.src_addr_o];
    end

    // Filter model: echoes pix+1 two stages after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v1 <= 1'b0; m_v2 <= 1'b0; m_p1 <= 8'd0; m_p2 <= 8'd0;
        end else begin
            m_v1 <= bus.flt_valid_o & bus.flt_ready_i;
            m_p1 <= bus.flt_pix_o + 8'd1;
            m_v2 <= m_v1;
            m_p2 <= m_p1;
        end
    end
    assign bus.flt_valid_i = m_v2 | stray_v;
    assign bus.flt_pix_i   = stray_v ? stray_p : m_p2;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.src_rd_o) begin
                if (src_n < 64) src_log[src_n] = int'(bus.src_addr_o);
                src_n++;
            end
            if (bus.dst_we_o) begin
                if (dst_n < 64) begin
                    dst_addr_log[dst_n] = int'(bus.dst_addr_o);
                    dst_data_log[dst_n] = int'(bus.dst_data_o);
                end
                dst_n++;
            end
            if (bus.flt_valid_o && bus.flt_ready_i) feed_n++;
        end
    end

    task automatic ctrl_write(input logic [31:0] d);
        bus.cs_i = 1'b1; bus.we_i = 1'b1; bus.sel_i = 1'b0; bus.wdata_i = d;
        @(negedge clk);
        bus.cs_i = 1'b0; bus.we_i = 1'b0; bus.wdata_i = 32'd0;
    endtask

    task automatic reg_read(input logic s, output logic [31:0] d);
        bus.cs_i = 1'b1; bus.we_i = 1'b0; bus.sel_i = s;
        #1;
        d = bus.rdata_o;
        bus.cs_i = 1'b0; bus.sel_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        logic [31:0] st;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            reg_read(1'b0, st);
            if (st[1]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] st;
        logic [47:0] outs;
        repeat (3) @(negedge clk);
        outs = {bus.src_rd_o, bus.flt_valid_o, bus.dst_we_o, bus.irq_o, bus.flt_pix_o,
                bus.dst_data_o, bus.src_addr_o, bus.dst_addr_o};
        n_checks++;
        if (outs !== 48'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 00000000", st); end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i + 100);
        bus.flt_ready_i = 1'b1;
        @(negedge clk);
        ctrl_write(32'h0008_0003);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        outs = {bus.src_rd_o, bus.flt_valid_o, bus.dst_we_o, bus.irq_o, bus.flt_pix_o,
                bus.dst_data_o, bus.src_addr_o, bus.dst_addr_o};
        n_checks++;
        if (outs !== 48'd0) begin n_fail++; $display("FAIL midstream_reset_outputs: got %h expected 0", outs); end
        @(negedge clk);
        rst_n = 1'b1;
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'd0) begin n_fail++; $display("FAIL midstream_reset_status: got %h expected 00000000", st); end
    endtask

    task automatic test_basic();
        logic [31:0] st;
        bit ok;
        int s0, d0;
        for (int i = 0; i < 4; i++) src_mem[i] = 8'((i + 1) * 10);
        bus.flt_ready_i = 1'b1;
        @(negedge clk);
        s0 = src_n; d0 = dst_n;
        ctrl_write(32'h0004_0003);
        n_checks++;
        if (bus.src_rd_o !== 1'b1 || bus.flt_valid_o !== 1'b0)
            begin n_fail++; $display("FAIL first_fetch: rd=%b valid=%b expected rd=1 valid=0", bus.src_rd_o, bus.flt_valid_o); end
        @(negedge clk);
        n_checks++;
        if (bus.flt_valid_o !== 1'b1 || bus.flt_pix_o !== 8'd10)
            begin n_fail++; $display("FAIL first_feed: valid=%b pix=%0d expected valid=1 pix=10", bus.flt_valid_o, bus.flt_pix_o); end
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: done not seen, expected done"); end
        n_checks++;
        if (src_n - s0 !== 4 || dst_n - d0 !== 4)
            begin n_fail++; $display("FAIL basic_counts: src=%0d dst=%0d expected 4 and 4", src_n - s0, dst_n - d0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (src_log[s0+i] !== i || dst_addr_log[d0+i] !== i || dst_data_log[d0+i] !== (i + 1) * 10 + 1)
                begin n_fail++; $display("FAIL basic_xfer[%0d]: src=%0d dst_addr=%0d dst_data=%0d expected %0d %0d %0d",
                                         i, src_log[s0+i], dst_addr_log[d0+i], dst_data_log[d0+i], i, i, (i + 1) * 10 + 1); end
        end
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'h0004_0006) begin n_fail++; $display("FAIL basic_status: got %h expected 00040006", st); end
        reg_read(1'b1, st);
        n_checks++;
        if (st !== 32'd41) begin n_fail++; $display("FAIL basic_data: got %0d expected 41", st); end
        @(negedge clk);
        n_checks++;
        if (bus.irq_o !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b expected 1", bus.irq_o); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int s0, d0, f0;
        bus.flt_ready_i = 1'b1;
        @(negedge clk);
        s0 = src_n; d0 = dst_n; f0 = feed_n;
        ctrl_write(32'h0004_0001);
        @(negedge clk);
        @(negedge clk);
        bus.flt_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.flt_valid_o !== 1'b1 || bus.flt_pix_o !== 8'd20 || bus.src_rd_o !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%b pix=%0d rd=%b expected 1 20 0",
                                         i, bus.flt_valid_o, bus.flt_pix_o, bus.src_rd_o); end
        end
        @(negedge clk);
        bus.flt_ready_i = 1'b1;
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: done not seen, expected done"); end
        n_checks++;
        if (src_n - s0 !== 4 || dst_n - d0 !== 4 || feed_n - f0 !== 4)
            begin n_fail++; $display("FAIL bp_counts: src=%0d dst=%0d feeds=%0d expected 4 4 4",
                                     src_n - s0, dst_n - d0, feed_n - f0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (src_log[s0+i] !== i || dst_data_log[d0+i] !== (i + 1) * 10 + 1)
                begin n_fail++; $display("FAIL bp_xfer[%0d]: src=%0d dst_data=%0d expected %0d %0d",
                                         i, src_log[s0+i], dst_data_log[d0+i], i, (i + 1) * 10 + 1); end
        end
    endtask

    task automatic test_n_zero();
        logic [31:0] st;
        int s0, d0;
        @(negedge clk);
        s0 = src_n; d0 = dst_n;
        ctrl_write(32'h0000_0003);
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'h0000_0006) begin n_fail++; $display("FAIL nzero_status: got %h expected 00000006", st); end
        @(negedge clk);
        n_checks++;
        if (bus.irq_o !== 1'b1) begin n_fail++; $display("FAIL nzero_irq: got %b expected 1", bus.irq_o); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (src_n !== s0 || dst_n !== d0)
            begin n_fail++; $display("FAIL nzero_traffic: src=%0d dst=%0d expected 0 0", src_n - s0, dst_n - d0); end
        ctrl_write(32'h0000_0006);
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'h0000_0004) begin n_fail++; $display("FAIL clr_done_status: got %h expected 00000004", st); end
        @(negedge clk);
        n_checks++;
        if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL clr_done_irq: got %b expected 0", bus.irq_o); end
    endtask

    task automatic test_busy_start_abort();
        logic [31:0] st;
        bit ok;
        bit hit;
        bit saw_valid;
        int s0, d0, f0;
        for (int i = 0; i < 6; i++) src_mem[i] = 8'(i + 1);
        bus.flt_ready_i = 1'b1;
        @(negedge clk);
        d0 = dst_n;
        ctrl_write(32'h0006_0001);
        ctrl_write(32'h0002_0001);
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL busy_timeout: done not seen, expected done"); end
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'h0006_0002) begin n_fail++; $display("FAIL busy_status: got %h expected 00060002", st); end
        n_checks++;
        if (dst_n - d0 !== 6) begin n_fail++; $display("FAIL busy_count: got %0d expected 6", dst_n - d0); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (dst_addr_log[d0+i] !== i || dst_data_log[d0+i] !== i + 2)
                begin n_fail++; $display("FAIL busy_xfer[%0d]: addr=%0d data=%0d expected %0d %0d",
                                         i, dst_addr_log[d0+i], dst_data_log[d0+i], i, i + 2); end
        end
        @(negedge clk);
        s0 = src_n; f0 = feed_n;
        ctrl_write(32'h0006_0001);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (feed_n - f0 == 3) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL abort_timeout: feeds=%0d expected 3", feed_n - f0); end
        ctrl_write(32'h0000_0008);
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'h0002_0000) begin n_fail++; $display("FAIL abort_status: got %h expected 00020000", st); end
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.flt_valid_o) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid || feed_n - f0 !== 3 || src_n - s0 !== 4)
            begin n_fail++; $display("FAIL abort_quiet: valid_seen=%b feeds=%0d src=%0d expected 0 3 4",
                                     saw_valid, feed_n - f0, src_n - s0); end
    endtask

    task automatic test_stray();
        logic [31:0] st;
        bit ok;
        int d0;
        @(negedge clk);
        d0 = dst_n;
        stray_v = 1'b1; stray_p = 8'hAA;
        #1;
        n_checks++;
        if (bus.dst_we_o !== 1'b0) begin n_fail++; $display("FAIL stray_idle_we: got %b expected 0", bus.dst_we_o); end
        @(negedge clk);
        stray_v = 1'b0;
        reg_read(1'b1, st);
        n_checks++;
        if (st !== 32'd3) begin n_fail++; $display("FAIL stray_idle_last: got %0d expected 3", st); end
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'h0002_0000) begin n_fail++; $display("FAIL stray_idle_status: got %h expected 00020000", st); end
        ctrl_write(32'h0001_0001);
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stray_timeout: done not seen, expected done"); end
        @(negedge clk);
        stray_v = 1'b1; stray_p = 8'h55;
        #1;
        n_checks++;
        if (bus.dst_we_o !== 1'b0) begin n_fail++; $display("FAIL stray_done_we: got %b expected 0", bus.dst_we_o); end
        @(negedge clk);
        stray_v = 1'b0;
        reg_read(1'b1, st);
        n_checks++;
        if (st !== 32'd2 || dst_n - d0 !== 1)
            begin n_fail++; $display("FAIL stray_done_last: data=%0d writes=%0d expected 2 1", st, dst_n - d0); end
        reg_read(1'b0, st);
        n_checks++;
        if (st !== 32'h0001_0002) begin n_fail++; $display("FAIL stray_done_status: got %h expected 00010002", st); end
    endtask

    initial begin
        bus.cs_i = 1'b0; bus.sel_i = 1'b0; bus.we_i = 1'b0; bus.wdata_i = 32'd0;
        bus.flt_ready_i = 1'b0;
        for (int i = 0; i < 1024; i++) src_mem[i] = 8'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_n_zero();
        test_busy_start_abort();
        test_stray();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gauss_ctrl.md
# gauss_ctrl

Memory-mapped sequencer for the Gaussian filter peripheral: owns the control/status register at offset 0x30 and the data register at 0x34 of the 0x2X3_ window. Once started by the CPU, it streams N pixels from the source pixel RAM into the filter datapath, writes the filtered pixels to the destination RAM, and signals completion by status bit and interrupt. It sits between the peripheral address decoder (whose `select` drives `sel_i`), the single-cycle RISC-V core's load/store bus, the two pixel RAMs, and the filter datapath.

## Interface
- ADDR_W, 10, pixel RAM address width; N ≤ 2^ADDR_W
- clk_i  in  1  system clock; one clock domain
- rst_n_i  in  1  reset, asynchronous, active-low
- cs_i  in  1  address falls in the 0x2X3_ filter window
- sel_i  in  1  decoder select: 0 = control/status (0x30), 1 = data (0x34)
- we_i  in  1  CPU store strobe
- wdata_i  in  32  CPU store data
- rdata_o  out  32  CPU load data, combinational
- src_rd_o  out  1  source RAM read enable
- src_addr_o  out  ADDR_W  source RAM address
- src_data_i  in  8  source pixel, valid one cycle after src_rd_o
- flt_valid_o  out  1  pixel to filter valid
- flt_pix_o  out  8  pixel to filter
- flt_ready_i  in  1  filter accepts pixel
- flt_valid_i  in  1  filtered pixel valid (always accepted)
- flt_pix_i  in  8  filtered pixel
- dst_we_o  out  1  destination RAM write enable
- dst_addr_o  out  ADDR_W  destination RAM address
- dst_data_o  out  8  destination RAM data
- irq_o  out  1  completion interrupt, level

## Operation
- Control write (cs_i & we_i & !sel_i): bit0 start, bit1 irq_en (stored), bit2 clr_done, bit3 abort; bits[16+ADDR_W:16] = N (stored only when start is accepted).
- Start is accepted only in IDLE or DONE; it is ignored while busy (irq_en is still updated).
- Status read (!sel_i): bit0 busy, bit1 done, bit2 irq_en, bits[16+ADDR_W:16] = out_cnt; all other bits 0. Data read (sel_i): {24'b0, last filtered pixel}. Data writes are ignored. rdata_o = 0 when !cs_i.
- FSM states: IDLE, FETCH, FEED, DRAIN, DONE.
  - IDLE/DONE: on accepted start, clear in_cnt, out_cnt, and done. If N = 0, go to DONE; otherwise go to FETCH.
  - FETCH: src_rd_o=1, src_addr_o=in_cnt; go to FEED.
  - FEED: capture src_data_i on entry and hold it in a pixel register; flt_valid_o=1. On flt_ready_i, in_cnt++. If in_cnt+1 == N, go to DRAIN; otherwise go to FETCH.
  - DRAIN: wait until out_cnt == N, then go to DONE.
  - DONE: done=1 until clr_done or the next start.
- Output path (FETCH/FEED/DRAIN): each flt_valid_i produces dst_we_o=1, dst_addr_o=out_cnt, dst_data_o=flt_pix_i, then out_cnt++ and the last-pixel register is updated. In IDLE/DONE, or once out_cnt == N, flt_valid_i is ignored.
- Abort in any busy state: go to IDLE next cycle; done is not set; counters are kept for readback.
- Simultaneous events: abort takes priority over start. clr_done in the same write as start: start wins and done is cleared either way.
- A completion cycle and a clr_done write in the same cycle: done ends at 1.
- irq_o = done & irq_en, registered.
- Counters are ADDR_W+1 bits wide, so N = 2^ADDR_W is allowed. Addresses use the low ADDR_W bits.

## Timing
- Reset: state IDLE; counters, pixel registers, done, and irq_en are 0; all outputs are 0.
- A start write in cycle t puts the block in FETCH at t+1 (src_rd_o high), with the first flt_valid_o at t+2.
- Feed throughput: 1 pixel per 2 cycles when flt_ready_i is held high.
- Under backpressure, flt_valid_o and flt_pix_o stay stable until flt_ready_i.
- dst_we_o is combinational from flt_valid_i in the same cycle; out_cnt updates at the following edge.
- done rises at the edge after the cycle in which out_cnt reaches N; irq_o follows one cycle later.
- Asynchronous reset mid-operation forces all state and outputs to reset values immediately; no RAM write occurs after reset asserts.

## Test plan
- Reset: rst_n_i low mid-stream with N=8 → all outputs 0 immediately; status reads 0x0 after release.
- N=4, flt_ready_i=1, filter model echoes pix+1 with 2-cycle latency, src RAM = {10,20,30,40} → src addresses 0..3, dst writes {11,21,31,41} to 0..3, status reads done=1 and out_cnt=4, data reads 41, irq_o=1 with irq_en=1.
- Backpressure: flt_ready_i low for 3 cycles on pixel 1 → flt_valid_o held and flt_pix_o stable at 20 for those cycles; no duplicate or skipped src address.
- N=0 start → DONE in 1 cycle, no src_rd_o, no dst_we_o, done=1; clr_done write → done=0, irq_o=0.
- Start with N=2 written while busy with N=6 → ignored; 6 pixels processed. Abort after 3 feeds → IDLE, done=0, in_cnt not advanced further.
- Stray flt_valid_i in IDLE and after out_cnt=N → no dst_we_o, and the last-pixel register is unchanged.
